// File: rtl/ahb_pkg.sv
// ahb_pkg -- shared AHB definitions for the slave-response path.
//   * HTRANS and HRESP encodings
//   * DSEL_DEFAULT: data-phase select value that routes to the default slave
//   * default-slave FSM state type
//   * is_active(): true for the transfer types that require a response
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  // Slots 0..3 are the real slaves; this value selects the default slave.
  localparam logic [2:0] DSEL_DEFAULT = 3'd4;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  // IDLE and BUSY carry no data, so they are never answered with ERROR.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage : ahb_pkg

// File: rtl/ahb_default_slave.sv
// ahb_default_slave -- answers active transfers to unpopulated slots with
// the two-cycle AHB ERROR response (one wait state, then ERROR with ready).
// Ports:
//   hclk    in   system clock
//   hreset  in   asynchronous active-high reset
//   start   in   an accepted address phase is an active transfer to a
//                masked slot (already qualified with hready)
//   hready  out  default-slave ready
//   hresp   out  default-slave response
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       hclk,
  input  logic       hreset,
  input  logic       start,
  output logic       hready,
  output logic [1:0] hresp
);

  ds_state_e state_q;
  ds_state_e state_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (start) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      // A new masked active transfer accepted in ERR2 chains straight into
      // the next error response with no IDLE gap.
      DS_ERR2: state_d = start ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    case (state_q)
      DS_ERR1: begin
        hready = 1'b0;
        hresp  = HRESP_ERROR;
      end
      DS_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

endmodule : ahb_default_slave

// File: rtl/ahb_mux.sv
// ahb_mux -- AHB response multiplexer for a four-slave fabric.
// Registers the address-phase slave select into the data phase and routes
// that slave's read data, ready and response back to the master. Slots with
// a clear SLAVE_MASK bit are served by the integrated default slave.
// Parameters:
//   DATA_WIDTH  read data width
//   SLAVE_MASK  bit i set = slave i+1 populated
// Ports:
//   hclk, hreset             clock, asynchronous active-high reset
//   sel, htrans              address-phase slave index and transfer type
//   hrdata_N, hreadyout_N,
//   hresp_N  (N = 1..4)      slave responses
//   hrdata, hready, hresp    response to the master (hready also gates the
//                            data-phase select register)
module ahb_mux
  import ahb_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] SLAVE_MASK = 4'b1111
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [1:0]            sel,
  input  logic [1:0]            htrans,
  input  logic [DATA_WIDTH-1:0] hrdata_1,
  input  logic [DATA_WIDTH-1:0] hrdata_2,
  input  logic [DATA_WIDTH-1:0] hrdata_3,
  input  logic [DATA_WIDTH-1:0] hrdata_4,
  input  logic                  hreadyout_1,
  input  logic                  hreadyout_2,
  input  logic                  hreadyout_3,
  input  logic                  hreadyout_4,
  input  logic [1:0]            hresp_1,
  input  logic [1:0]            hresp_2,
  input  logic [1:0]            hresp_3,
  input  logic [1:0]            hresp_4,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic [1:0]            hresp
);

  logic [2:0] dsel;
  logic       dact;
  logic [2:0] dsel_d;
  logic       act_d;
  logic       ds_start;
  logic       ds_hready;
  logic [1:0] ds_hresp;

  assign act_d    = is_active(htrans);
  assign dsel_d   = SLAVE_MASK[sel] ? {1'b0, sel} : DSEL_DEFAULT;
  // sel/htrans only reach registers, never the outputs directly.
  assign ds_start = hready && act_d && (dsel_d == DSEL_DEFAULT);

  // The data-phase select freezes while the current data phase is stalled.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dsel <= DSEL_DEFAULT;
      dact <= 1'b0;
    end else if (hready) begin
      dsel <= dsel_d;
      dact <= act_d;
    end
  end

  ahb_default_slave u_default_slave (
    .hclk   (hclk),
    .hreset (hreset),
    .start  (ds_start),
    .hready (ds_hready),
    .hresp  (ds_hresp)
  );

  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    case (dsel)
      3'd0: begin
        hrdata = hrdata_1;
        hready = hreadyout_1;
        hresp  = hresp_1;
      end
      3'd1: begin
        hrdata = hrdata_2;
        hready = hreadyout_2;
        hresp  = hresp_2;
      end
      3'd2: begin
        hrdata = hrdata_3;
        hready = hreadyout_3;
        hresp  = hresp_3;
      end
      3'd3: begin
        hrdata = hrdata_4;
        hready = hreadyout_4;
        hresp  = hresp_4;
      end
      default: begin
        // Default slot: an inactive transfer gets a zero-wait OKAY; the FSM
        // is idle in that case anyway, dact just makes the intent explicit.
        if (dact) begin
          hready = ds_hready;
          hresp  = ds_hresp;
        end
      end
    endcase
  end

endmodule : ahb_mux

// File: tb/tb_ahb_mux.sv
// tb_ahb_mux -- scoreboard bench for ahb_mux with slave 4 unpopulated.
// The driver issues per-cycle stimulus and pushes the hand-computed response
// for that cycle; the monitor pops and compares on the falling edge (or on
// an explicit probe event for the mid-cycle asynchronous reset).
module tb_ahb_mux;
  import ahb_pkg::*;

  localparam int DW = 32;
  localparam logic [DW-1:0] D1 = 32'h1111_0001;
  localparam logic [DW-1:0] D3 = 32'hA5A5_0003;
  localparam logic [DW-1:0] D4 = 32'h4444_0004;

  logic          hclk = 1'b0;
  logic          hreset;
  logic [1:0]    sel, htrans;
  logic [DW-1:0] hrdata_1, hrdata_2, hrdata_3, hrdata_4;
  logic          hreadyout_1, hreadyout_2, hreadyout_3, hreadyout_4;
  logic [1:0]    hresp_1, hresp_2, hresp_3, hresp_4;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic [1:0]    hresp;

  ahb_mux #(.DATA_WIDTH(DW), .SLAVE_MASK(4'b0111)) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .sel         (sel),
    .htrans      (htrans),
    .hrdata_1    (hrdata_1),
    .hrdata_2    (hrdata_2),
    .hrdata_3    (hrdata_3),
    .hrdata_4    (hrdata_4),
    .hreadyout_1 (hreadyout_1),
    .hreadyout_2 (hreadyout_2),
    .hreadyout_3 (hreadyout_3),
    .hreadyout_4 (hreadyout_4),
    .hresp_1     (hresp_1),
    .hresp_2     (hresp_2),
    .hresp_3     (hresp_3),
    .hresp_4     (hresp_4),
    .hrdata      (hrdata),
    .hready      (hready),
    .hresp       (hresp)
  );

  always #5 hclk = ~hclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ready;
    logic [1:0]    resp;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  event  probe_ev;

  task automatic push_exp(input string name, input logic [DW-1:0] d,
                          input logic r, input logic [1:0] s);
    exp_t e;
    e.data  = d;
    e.ready = r;
    e.resp  = s;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic check();
    exp_t  e;
    string n;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    tests_run++;
    if (hrdata !== e.data || hready !== e.ready || hresp !== e.resp) begin
      tests_failed++;
      $display("FAIL %s: got hrdata=%h hready=%b hresp=%b, expected hrdata=%h hready=%b hresp=%b",
               n, hrdata, hready, hresp, e.data, e.ready, e.resp);
    end
  endtask

  // Monitor: compares whatever the driver has queued for this sample point.
  initial begin
    forever begin
      @(negedge hclk or probe_ev);
      if (exp_q.size() > 0) check();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hreset      = 1'b1;
    sel         = 2'd0;
    htrans      = HTRANS_IDLE;
    hrdata_1    = $urandom;
    hrdata_2    = $urandom;
    hrdata_3    = $urandom;
    hrdata_4    = $urandom;
    hreadyout_1 = 1'($urandom_range(0, 1));
    hreadyout_2 = 1'($urandom_range(0, 1));
    hreadyout_3 = 1'($urandom_range(0, 1));
    hreadyout_4 = 1'($urandom_range(0, 1));
    hresp_1     = 2'($urandom_range(0, 3));
    hresp_2     = 2'($urandom_range(0, 3));
    hresp_3     = 2'($urandom_range(0, 3));
    hresp_4     = 2'($urandom_range(0, 3));

    repeat (2) cyc();
    push_exp("reset", '0, 1'b1, HRESP_OKAY);

    // Release with an active address phase to slave 3 already presented.
    cyc();
    hreset      = 1'b0;
    sel         = 2'd2;
    htrans      = HTRANS_NONSEQ;
    hrdata_1    = D1;
    hrdata_2    = 32'h2222_0000;
    hrdata_3    = D3;
    hrdata_4    = D4;
    hreadyout_1 = 1'b1;
    hreadyout_2 = 1'b1;
    hreadyout_3 = 1'b1;
    hreadyout_4 = 1'b1;
    hresp_1     = HRESP_OKAY;
    hresp_2     = HRESP_OKAY;
    hresp_3     = HRESP_OKAY;
    hresp_4     = HRESP_OKAY;
    push_exp("release_hold", '0, 1'b1, HRESP_OKAY);

    // Data phase of slave 3; sel moves to slave 2 without disturbing it.
    cyc();
    sel = 2'd1;
    push_exp("route_s3", D3, 1'b1, HRESP_OKAY);

    // Slave 2 stalls three cycles while sel wanders, including to slot 4.
    cyc();
    hreadyout_2 = 1'b0;
    hrdata_2    = 32'h2222_0001;
    sel         = 2'd0;
    push_exp("wait1", 32'h2222_0001, 1'b0, HRESP_OKAY);
    cyc();
    hrdata_2 = 32'h2222_0002;
    sel      = 2'd3;
    push_exp("wait2", 32'h2222_0002, 1'b0, HRESP_OKAY);
    cyc();
    hrdata_2 = 32'h2222_0003;
    sel      = 2'd0;
    push_exp("wait3", 32'h2222_0003, 1'b0, HRESP_OKAY);
    cyc();
    hreadyout_2 = 1'b1;
    hrdata_2    = 32'h2222_0004;
    push_exp("wait_done", 32'h2222_0004, 1'b1, HRESP_OKAY);

    // Slave 1 data phase; address phase: NONSEQ to masked slot 4.
    cyc();
    sel    = 2'd3;
    htrans = HTRANS_NONSEQ;
    push_exp("route_s1", D1, 1'b1, HRESP_OKAY);
    cyc();
    sel    = 2'd0;
    htrans = HTRANS_IDLE;
    push_exp("err1", '0, 1'b0, HRESP_ERROR);
    cyc();
    push_exp("err2", '0, 1'b1, HRESP_ERROR);
    cyc();
    sel    = 2'd3;
    htrans = HTRANS_IDLE;
    push_exp("after_err", D1, 1'b1, HRESP_OKAY);
    cyc();
    htrans = HTRANS_BUSY;
    push_exp("masked_idle", '0, 1'b1, HRESP_OKAY);
    cyc();
    htrans = HTRANS_NONSEQ;
    push_exp("masked_busy", '0, 1'b1, HRESP_OKAY);

    // Back-to-back masked active transfers.
    cyc();
    htrans = HTRANS_SEQ;
    push_exp("b2b_err1a", '0, 1'b0, HRESP_ERROR);
    cyc();
    push_exp("b2b_err2a", '0, 1'b1, HRESP_ERROR);
    cyc();
    htrans = HTRANS_NONSEQ;
    push_exp("b2b_err1b", '0, 1'b0, HRESP_ERROR);
    cyc();
    push_exp("b2b_err2b", '0, 1'b1, HRESP_ERROR);

    // Reset pulsed in the middle of an ERR1 cycle.
    cyc();
    push_exp("abort_pre", '0, 1'b0, HRESP_ERROR);
    @(negedge hclk);
    #1;
    hreset = 1'b1;
    push_exp("abort_async", '0, 1'b1, HRESP_OKAY);
    #1;
    -> probe_ev;
    cyc();
    push_exp("abort_hold", '0, 1'b1, HRESP_OKAY);
    cyc();
    hreset = 1'b0;
    sel    = 2'd2;
    htrans = HTRANS_NONSEQ;
    push_exp("abort_release", '0, 1'b1, HRESP_OKAY);
    cyc();
    sel    = 2'd0;
    htrans = HTRANS_IDLE;
    push_exp("first_load", D3, 1'b1, HRESP_OKAY);

    // A real slave's ERROR is passed through unchanged.
    cyc();
    hreadyout_1 = 1'b0;
    hresp_1     = HRESP_ERROR;
    push_exp("s1_err_pass", D1, 1'b0, HRESP_ERROR);
    cyc();
    hreadyout_1 = 1'b1;
    hresp_1     = HRESP_OKAY;
    push_exp("s1_okay", D1, 1'b1, HRESP_OKAY);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge hclk);
    #1;
    while (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_%s: got no sample, expected a monitor comparison", name_q[0]);
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_ahb_mux

// File: doc/ahb_mux.md
# ahb_mux

AHB response multiplexer for the four-slave fabric. It carries slave-to-master traffic in the opposite direction to the address decoder, which fans `sel` out to `hsel_1`..`hsel_4`. It registers the address-phase slave select into the data phase and routes that slave's `hrdata`/`hreadyout`/`hresp` back to the master. An integrated default slave answers transfers aimed at masked (unpopulated) slots with the two-cycle AHB ERROR response.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of the read data buses.
- `SLAVE_MASK`, 4'b1111: bit i set means slave i+1 is populated. A clear bit routes that slot to the default slave.

Ports:
- `hclk`  in  1  system clock; all state updates on the rising edge.
- `hreset`  in  1  asynchronous, active-high reset. One clock, `hclk`; reset asynchronous and active-high.
- `sel`  in  2  address-phase slave index, same encoding as the decoder (00→slave 1 … 11→slave 4).
- `htrans`  in  2  address-phase transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- `hrdata_1`..`hrdata_4`  in  DATA_WIDTH  slave read data.
- `hreadyout_1`..`hreadyout_4`  in  1  slave ready.
- `hresp_1`..`hresp_4`  in  2  slave response (OKAY=00, ERROR=01, RETRY=10, SPLIT=11).
- `hrdata`  out  DATA_WIDTH  read data to master.
- `hready`  out  1  transfer done / bus ready; also fed back internally as the phase-advance qualifier.
- `hresp`  out  2  response to master.

## Operation
- **Data-phase select register `dsel` (3 bits).**
  - Values 0–3 select slave 1–4; value 4 selects DEFAULT.
  - Loads on `hclk` edge only when `hready`=1.
  - Load value is `sel` if `SLAVE_MASK[sel]`=1, else DEFAULT.
  - Holds while `hready`=0, even if `sel` or `htrans` change.
- **Active flag `dact`.** Loads with `hready` as `htrans` is NONSEQ or SEQ. Meaningful only when `dsel`=DEFAULT.
- **Slave routing.** When `dsel` is 0–3, outputs pass the selected slave's `hrdata_*`/`hreadyout_*`/`hresp_*` combinationally.
- **DEFAULT routing.**
  - `hrdata` = 0.
  - `hready`/`hresp` come from the default-slave FSM.
- **Default-slave FSM.** States IDLE, ERR1, ERR2.
  - IDLE: `hready`=1, `hresp`=OKAY. Goes to ERR1 when a load takes `dsel`=DEFAULT with `dact`=1.
  - ERR1: `hready`=0, `hresp`=ERROR. Always goes to ERR2 next cycle.
  - ERR2: `hready`=1, `hresp`=ERROR. Goes to ERR1 if the address phase sampled this cycle is again an active transfer to a masked slot, else to IDLE.
- **IDLE/BUSY transfers.** An IDLE or BUSY transfer to a masked slot gets a zero-wait OKAY, not ERROR.
- **Reset values.**
  - `dsel`=DEFAULT, `dact`=0, FSM=IDLE.
  - Therefore `hrdata`=0, `hready`=1, `hresp`=OKAY.

## Timing
- Address phase in cycle N with `hready`=1 → the data phase is cycle N+1, and the routed outputs are visible combinationally in N+1.
- Slave wait states extend the data phase: `hready` follows the selected `hreadyout_*` and `dsel` is frozen until it returns to 1.
- An ERROR response from a real slave is passed through unchanged; its two-cycle timing is the slave's responsibility.
- Default ERROR adds exactly one wait state: ERR1 in cycle N+1, ERR2 in N+2. The next address phase is accepted at the end of N+2.
- Back-to-back masked active transfers produce the repeating pattern ERR1, ERR2, ERR1, ERR2 with no IDLE gap.
- Reset asserted mid-transfer (including ERR1) forces the reset values immediately (asynchronous), abandoning the transfer. First load after deassertion occurs on the first `hclk` edge, since `hready`=1.
- No combinational path from `sel`/`htrans` to any output. The only path is from the slave inputs to the outputs.

## Structure
- Shared package `ahb_pkg`:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ).
  - HRESP codes (OKAY, ERROR, RETRY, SPLIT).
  - Constant `DSEL_DEFAULT`=3'd4.
  - FSM state enum for the default slave.
- One sub-module, `ahb_default_slave`: inputs `hclk`, `hreset`, `start` (qualified load of an active masked transfer); outputs `hready`, `hresp`.
- `ahb_mux` holds `dsel`/`dact` and the output multiplexer.

## Test plan
- **Reset:** assert `hreset` with slave inputs at random values → `hrdata`=0, `hready`=1, `hresp`=00. Values hold until the first edge after release.
- **Routing:** `sel`=10, `htrans`=NONSEQ, `hrdata_3`=32'hA5A5_0003, all `hreadyout_*`=1 → next cycle `hrdata`=32'hA5A5_0003, `hresp`=00. Change `sel` to 01 in the same cycle → outputs unaffected until the following edge.
- **Wait state:** slave 2 selected, `hreadyout_2` low for 3 cycles while `sel` toggles → `hready`=0 for 3 cycles, `hrdata` tracks `hrdata_2` throughout, `dsel` unchanged.
- **Default error:** `SLAVE_MASK`=4'b0111, `sel`=11, NONSEQ → cycle N+1 `hready`=0/`hresp`=01, cycle N+2 `hready`=1/`hresp`=01, then OKAY. Same with `htrans`=IDLE → zero-wait OKAY.
- **Back-to-back and reset abort:** two consecutive masked NONSEQ transfers → ERR1, ERR2, ERR1, ERR2. Then `hreset` pulsed during ERR1 → immediate `hready`=1, `hresp`=00.
